top: RTL and testbench



---
 rtl/top_pkg.sv | 25 ++
 rtl/top_dmem.sv | 25 ++
 rtl/top.sv | 234 +++++++++++++++++++++++
 tb/tb_top.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/top_pkg.sv
// Shared definitions for the matrix-multiply core and its data memory.
// State codes, memory geometry and port-owner encodings.
package top_pkg;

  localparam int DW    = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  localparam logic [1:0] MODE_CORE = 2'd0;
  localparam logic [1:0] MODE_WR   = 2'd1;
  localparam logic [1:0] MODE_RD   = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_RDN  = 4'd1,
    S_LDN  = 4'd2,
    S_RDA  = 4'd3,
    S_RDB  = 4'd4,
    S_MAC  = 4'd5,
    S_STO  = 4'd6,
    S_NXT  = 4'd7,
    S_DONE = 4'd8
  } state_t;

endpackage

// File: rtl/top_dmem.sv
// 1024x16 single-port synchronous RAM.
// Read data is registered; the reset clears only the read register.
module top_dmem
  import top_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[addr];
  end

endmodule

// File: rtl/top.sv
// Square-matrix multiply core C = A x B over a shared data memory.
// The bench may borrow the memory port; the core stalls while it does.
module top
  import top_pkg::*;
(
  input  logic        clk,
  input  logic        RESET,
  input  logic        START,
  output logic        END,
  input  logic [1:0]  addr_mux_select,
  input  logic [15:0] ar_in,
  input  logic [15:0] current_addr,
  input  logic        write_from_tb,
  input  logic [15:0] mem_data,
  output logic [15:0] dmem_out_disp,
  output logic [15:0] dmem_disp,
  output logic [15:0] memory_in_addr,
  output logic        d_read_status,
  output logic        d_write_status,
  output logic        d_write_status_all,
  output logic [15:0] imem_disp,
  output logic [15:0] ir_out_disp,
  output logic        i_read_status,
  output logic [48:0] ops_disp,
  output logic [15:0] pc_disp,
  output logic        inc_pc_disp,
  output logic        lddr_disp,
  output logic        corrected_clk_disp,
  output logic [15:0] ar_disp,
  output logic [15:0] dr_disp,
  output logic [15:0] bus_disp,
  output logic [15:0] n_disp,
  output logic [15:0] c_disp,
  output logic [15:0] ic_disp,
  output logic [15:0] ie_disp,
  output logic [15:0] i_disp,
  output logic [15:0] j_disp,
  output logic [15:0] tp1_disp,
  output logic [15:0] tp2_disp,
  output logic [15:0] tp3_disp,
  output logic [15:0] count_disp,
  output logic [15:0] ac_disp,
  output logic [15:0] tr_disp,
  output logic [15:0] alu_disp,
  output logic        z_disp,
  output logic        endinc_disp
);

  state_t state, state_d;

  logic [15:0] ar, dr, bus, n, c, ic, ie;
  logic [15:0] i, j, tp1, tp2, tp3;
  logic [15:0] count, ac, tr, pc;

  logic [15:0] rdata, core_addr, mem_addr;
  logic [15:0] mem_wdata, alu, alu_b;
  logic [15:0] n_m1, n_sq, ic_init, c_init;
  logic        stall, tb_we, core_we;
  logic        last_k, more, inc_pc;

  assign stall = (addr_mux_select == MODE_WR) ||
                 (addr_mux_select == MODE_RD);
  assign tb_we = (addr_mux_select == MODE_WR) && write_from_tb;
  assign core_we = (state == S_STO) && !stall;

  // Reads are issued from the pointer that AR is about to take.
  always_comb begin
    core_addr = ar;
    unique case (1'b1)
      state == S_RDA: core_addr = tp1;
      state == S_RDB: core_addr = tp2;
      state == S_STO: core_addr = tp3;
      default:        core_addr = ar;
    endcase
  end

  always_comb begin
    mem_addr = core_addr;
    case (addr_mux_select)
      MODE_WR: mem_addr = current_addr;
      MODE_RD: mem_addr = ar_in;
      default: mem_addr = core_addr;
    endcase
  end

  assign mem_wdata = tb_we ? mem_data : ac;

  top_dmem u_dmem (
    .clk   (clk),
    .rst   (RESET),
    .we    ((tb_we || core_we) && !RESET),
    .addr  (mem_addr[AW-1:0]),
    .wdata (mem_wdata),
    .rdata (rdata)
  );

  assign n_m1    = n - 16'd1;
  assign last_k  = count == n_m1;
  assign more    = (j < n_m1) || (i < n_m1);
  assign n_sq    = rdata * rdata;
  assign ic_init = n_sq + 16'd1;
  assign c_init  = (n_sq << 1) + 16'd1;
  assign alu_b   = (state == S_MAC) ? rdata : dr;
  assign alu     = ac + tr * alu_b;

  always_ff @(posedge clk) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (!stall) begin
      unique case (state)
        S_IDLE, S_DONE: if (START) state_d = S_RDN;
        S_RDN: state_d = S_LDN;
        S_LDN: state_d = (rdata == '0) ? S_DONE : S_RDA;
        S_RDA: state_d = S_RDB;
        S_RDB: state_d = S_MAC;
        S_MAC: state_d = last_k ? S_STO : S_RDA;
        S_STO: state_d = S_NXT;
        S_NXT: state_d = more ? S_RDA : S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A new run restarts PC, so only in-run transitions count.
  assign inc_pc = !stall && (state_d != state) &&
                  (state != S_IDLE) && (state != S_DONE);

  always_ff @(posedge clk) begin
    if (RESET) begin
      ar <= '0; dr <= '0; bus <= '0; n <= '0;
      c <= '0; ic <= '0; ie <= '0; i <= '0;
      j <= '0; tp1 <= '0; tp2 <= '0; tp3 <= '0;
      count <= '0; ac <= '0; tr <= '0; pc <= '0;
    end else if (!stall) begin
      if (inc_pc) pc <= pc + 16'd1;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            ar <= '0;
            pc <= '0;
          end
        end
        S_LDN: begin
          dr <= rdata;
          n <= rdata;
          i <= '0;
          j <= '0;
          count <= '0;
          ac <= '0;
          c <= c_init;
          ic <= ic_init;
          tp1 <= 16'd1;
          tp2 <= ic_init;
          tp3 <= c_init;
        end
        S_RDA: ar <= tp1;
        S_RDB: begin
          tr <= rdata;
          ar <= tp2;
        end
        S_MAC: begin
          dr <= rdata;
          ac <= alu;
          if (!last_k) begin
            count <= count + 16'd1;
            tp1 <= tp1 + 16'd1;
            tp2 <= tp2 + n;
          end
        end
        S_STO: begin
          bus <= ac;
          ie <= ie + 16'd1;
        end
        S_NXT: begin
          ac <= '0;
          count <= '0;
          tp3 <= tp3 + 16'd1;
          if (j < n_m1) begin
            j <= j + 16'd1;
            tp1 <= 16'd1 + i * n;
            tp2 <= ic + j + 16'd1;
          end else if (i < n_m1) begin
            i <= i + 16'd1;
            j <= '0;
            tp1 <= 16'd1 + (i + 16'd1) * n;
            tp2 <= ic;
          end
        end
        default: ;
      endcase
    end
  end

  assign END                = state == S_DONE;
  assign dmem_out_disp      = rdata;
  assign dmem_disp          = mem_wdata;
  assign memory_in_addr     = mem_addr;
  assign d_read_status      = !stall && ((state == S_RDN) ||
                              (state == S_RDA) || (state == S_RDB));
  assign d_write_status     = core_we;
  assign d_write_status_all = tb_we || core_we;
  assign imem_disp          = {12'd0, state};
  assign ir_out_disp        = {12'd0, state};
  assign i_read_status      = state == S_IDLE;
  assign ops_disp           = 49'd1 << state;
  assign pc_disp            = pc;
  assign inc_pc_disp        = inc_pc;
  assign lddr_disp          = !stall && ((state == S_LDN) ||
                              (state == S_MAC));
  assign corrected_clk_disp = clk;
  assign ar_disp            = ar;
  assign dr_disp            = dr;
  assign bus_disp           = bus;
  assign n_disp             = n;
  assign c_disp             = c;
  assign ic_disp            = ic;
  assign ie_disp            = ie;
  assign i_disp             = i;
  assign j_disp             = j;
  assign tp1_disp           = tp1;
  assign tp2_disp           = tp2;
  assign tp3_disp           = tp3;
  assign count_disp         = count;
  assign ac_disp            = ac;
  assign tr_disp            = tr;
  assign alu_disp           = alu;
  assign z_disp             = alu == '0;
  assign endinc_disp        = (state == S_MAC) && last_k;

endmodule

// File: tb/tb_top.sv
// Directed and randomized checks of the matrix-multiply core.
// Expected products come from a plain nested-loop matrix model.
module tb_top;

  logic        clk = 1'b0;
  logic        RESET, START, END;
  logic [1:0]  addr_mux_select;
  logic [15:0] ar_in, current_addr, mem_data;
  logic        write_from_tb;
  logic [15:0] dmem_out_disp, dmem_disp, memory_in_addr;
  logic        d_read_status, d_write_status, d_write_status_all;
  logic [15:0] imem_disp, ir_out_disp, pc_disp;
  logic        i_read_status, inc_pc_disp, lddr_disp;
  logic        corrected_clk_disp, z_disp, endinc_disp;
  logic [48:0] ops_disp;
  logic [15:0] ar_disp, dr_disp, bus_disp, n_disp, c_disp, ic_disp;
  logic [15:0] ie_disp, i_disp, j_disp, tp1_disp, tp2_disp;
  logic [15:0] tp3_disp, count_disp, ac_disp, tr_disp, alu_disp;

  int compared = 0;
  int mismatched = 0;
  int wr_cnt = 0;

  int n_v;
  int a_v [0:24];
  int b_v [0:24];

  always #5 clk = ~clk;

  always @(negedge clk) if (d_write_status_all) wr_cnt++;

  top dut (
    .clk(clk), .RESET(RESET), .START(START), .END(END),
    .addr_mux_select(addr_mux_select), .ar_in(ar_in),
    .current_addr(current_addr), .write_from_tb(write_from_tb),
    .mem_data(mem_data), .dmem_out_disp(dmem_out_disp),
    .dmem_disp(dmem_disp), .memory_in_addr(memory_in_addr),
    .d_read_status(d_read_status), .d_write_status(d_write_status),
    .d_write_status_all(d_write_status_all),
    .imem_disp(imem_disp), .ir_out_disp(ir_out_disp),
    .i_read_status(i_read_status), .ops_disp(ops_disp),
    .pc_disp(pc_disp), .inc_pc_disp(inc_pc_disp),
    .lddr_disp(lddr_disp), .corrected_clk_disp(corrected_clk_disp),
    .ar_disp(ar_disp), .dr_disp(dr_disp), .bus_disp(bus_disp),
    .n_disp(n_disp), .c_disp(c_disp), .ic_disp(ic_disp),
    .ie_disp(ie_disp), .i_disp(i_disp), .j_disp(j_disp),
    .tp1_disp(tp1_disp), .tp2_disp(tp2_disp), .tp3_disp(tp3_disp),
    .count_disp(count_disp), .ac_disp(ac_disp), .tr_disp(tr_disp),
    .alu_disp(alu_disp), .z_disp(z_disp), .endinc_disp(endinc_disp)
  );

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
  endtask

  task automatic tb_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    addr_mux_select = 2'd1;
    current_addr = a;
    mem_data = d;
    write_from_tb = 1'b1;
    @(negedge clk);
    write_from_tb = 1'b0;
    addr_mux_select = 2'd0;
  endtask

  task automatic tb_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    addr_mux_select = 2'd2;
    ar_in = a;
    @(negedge clk);
    d = dmem_out_disp;
    addr_mux_select = 2'd0;
  endtask

  task automatic load_case();
    tb_write(16'd0, 16'(n_v));
    for (int k = 0; k < n_v * n_v; k++) begin
      tb_write(16'(1 + k), 16'(a_v[k]));
      tb_write(16'(1 + n_v * n_v + k), 16'(b_v[k]));
    end
  endtask

  // cyc counts rising edges from the one that samples START.
  task automatic run_wait(output int cyc);
    @(negedge clk);
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    cyc = 1;
    while (!END && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("run_end", {15'd0, END}, 16'd1);
  endtask

  task automatic check_results(input string tag);
    logic [15:0] got;
    int acc;
    for (int r = 0; r < n_v; r++) begin
      for (int col = 0; col < n_v; col++) begin
        acc = 0;
        for (int k = 0; k < n_v; k++)
          acc += a_v[r * n_v + k] * b_v[k * n_v + col];
        tb_read(16'(1 + 2 * n_v * n_v + r * n_v + col), got);
        check(tag, got, 16'(acc & 32'hFFFF));
      end
    end
  endtask

  task automatic set_n2();
    n_v = 2;
    a_v[0] = 1; a_v[1] = 2; a_v[2] = 3; a_v[3] = 4;
    b_v[0] = 5; b_v[1] = 6; b_v[2] = 7; b_v[3] = 8;
  endtask

  initial begin
    int cyc;
    int w0;
    logic [15:0] got;
    logic [15:0] pc_save;
    bit found;

    RESET = 1'b1;
    START = 1'b0;
    addr_mux_select = 2'd0;
    ar_in = '0;
    current_addr = '0;
    mem_data = '0;
    write_from_tb = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_end", {15'd0, END}, 16'd0);
    check("rst_state", imem_disp, 16'd0);
    check("rst_pc", pc_disp, 16'd0);
    check("rst_ac", ac_disp, 16'd0);
    check("rst_ie", ie_disp, 16'd0);
    check("rst_rdata", dmem_out_disp, 16'd0);
    check("rst_idle", {15'd0, i_read_status}, 16'd1);
    RESET = 1'b0;

    set_n2();
    load_case();
    run_wait(cyc);
    check_results("n2_c");
    check("n2_ie", ie_disp, 16'd4);
    tb_read(16'd9, got);
    check("n2_c00_lit", got, 16'd19);
    tb_read(16'd12, got);
    check("n2_c11_lit", got, 16'd50);

    do_reset();
    n_v = 1; a_v[0] = 3; b_v[0] = 5;
    load_case();
    run_wait(cyc);
    check_results("n1_c");
    check("n1_ie", ie_disp, 16'd1);

    do_reset();
    n_v = 1; a_v[0] = 300; b_v[0] = 300;
    load_case();
    run_wait(cyc);
    check_results("n1_wrap");
    tb_read(16'd3, got);
    check("n1_wrap_lit", got, 16'd24464);

    do_reset();
    tb_write(16'd0, 16'd0);
    tb_write(16'd1, 16'd1234);
    w0 = wr_cnt;
    run_wait(cyc);
    check("n0_lat", {15'd0, cyc <= 3}, 16'd1);
    check("n0_nowrite", 16'(wr_cnt - w0), 16'd0);
    tb_read(16'd1, got);
    check("n0_sentinel", got, 16'd1234);

    do_reset();
    set_n2();
    load_case();
    tb_write(16'd9, 16'd0);
    @(negedge clk);
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (imem_disp == 16'd5) found = 1'b1;
      else @(negedge clk);
    end
    check("mac_reached", {15'd0, found}, 16'd1);
    RESET = 1'b1;
    @(negedge clk);
    check("mrst_state", imem_disp, 16'd0);
    check("mrst_end", {15'd0, END}, 16'd0);
    check("mrst_ac", ac_disp, 16'd0);
    check("mrst_tp1", tp1_disp, 16'd0);
    check("mrst_n", n_disp, 16'd0);
    check("mrst_pc", pc_disp, 16'd0);
    RESET = 1'b0;
    run_wait(cyc);
    check_results("rerun_c");

    pc_save = pc_disp;
    @(negedge clk);
    addr_mux_select = 2'd1;
    current_addr = 16'd500;
    mem_data = 16'hBEEF;
    write_from_tb = 1'b1;
    START = 1'b1;
    @(negedge clk);
    check("stall_wr_state", imem_disp, 16'd8);
    check("stall_wr_pc", pc_disp, pc_save);
    START = 1'b0;
    write_from_tb = 1'b0;
    addr_mux_select = 2'd2;
    ar_in = 16'd500;
    check("rd_addr", memory_in_addr, 16'd500);
    @(negedge clk);
    check("rd_beef", dmem_out_disp, 16'hBEEF);
    check("stall_rd_state", imem_disp, 16'd8);
    check("stall_end", {15'd0, END}, 16'd1);
    addr_mux_select = 2'd0;

    for (int t = 0; t < 4; t++) begin
      do_reset();
      n_v = int'($urandom_range(1, 4));
      for (int k = 0; k < n_v * n_v; k++) begin
        a_v[k] = int'($urandom_range(0, 65535));
        b_v[k] = int'($urandom_range(0, 65535));
      end
      load_case();
      run_wait(cyc);
      check_results("rand_c");
      check("rand_ie", ie_disp, 16'(n_v * n_v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
